alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Command-side driver for the combinational logical unit (LU) of the ALU.
//  Accepts packed commands over a valid/ready handshake and owns a 4-entry x N-bit register file.
//  Decodes each command and drives registered A/B/instruction to the LU.
//  Captures LU_out, writes it back and returns it on a valid/ready response channel.
// PARAMETERS
//  N  4  data width: LU operands, register file entries, immediate, response
//  M  4  opcode width; low M-1 bits are the LU instruction, MSB selects LOADI
// PORTS
//  clk            in   1    single clock, rising edge
//  reset          in   1    asynchronous, active-high
//  cmd_valid      in   1    command present
//  cmd_ready      out  1    sequencer can accept a command
//  cmd_op         in   M    [M-1]=1: LOADI; [M-1]=0: LU op, code = cmd_op[M-2:0]
//  cmd_rd         in   2    destination register
//  cmd_rs1        in   2    source register for A
//  cmd_rs2        in   2    source register for B
//  cmd_imm        in   N    immediate, used by LOADI only
//  lu_a           out  N    operand A to LU (registered)
//  lu_b           out  N    operand B to LU (registered)
//  lu_instruction out  M-1  LU op code (registered)
//  lu_result      in   N    LU_out, combinational from lu_a/lu_b/lu_instruction
//  rsp_valid      out  1    result available
//  rsp_ready      in   1    consumer accepts result
//  rsp_data       out  N    value written to rd
//  rsp_rd         out  2    register that was written
// BEHAVIOUR
//  Reset (async, immediate):
//   - state=IDLE; all registers, lu_a, lu_b, lu_instruction, rsp_data and rsp_rd clear to 0; rsp_valid=0.
//   - cmd_ready=0 while reset is high.
//  cmd_ready = (state==IDLE). Accept = cmd_valid & cmd_ready at a rising edge.
//  FSM states: IDLE, EXEC, RESP.
//  IDLE, accept of an LU op:
//   - lu_a<=rf[rs1], lu_b<=rf[rs2], lu_instruction<=cmd_op[M-2:0], latch rd.
//   - Next state EXEC.
//  IDLE, accept of LOADI:
//   - rf[rd]<=cmd_imm, rsp_data<=cmd_imm, rsp_rd<=rd.
//   - Next state RESP. lu_* are unchanged.
//  EXEC (exactly 1 cycle):
//   - rf[rd]<=lu_result, rsp_data<=lu_result, rsp_rd<=rd.
//   - Next state RESP.
//  RESP:
//   - rsp_valid=1.
//   - If rsp_ready, go to IDLE; otherwise hold, with rsp_data/rsp_rd stable.
//  Latency, accept edge to rsp_valid high: LU op 2 cycles, LOADI 1 cycle.
//  Throughput: 1 command per 3 cycles (LU op) or per 2 cycles (LOADI) with rsp_ready held high.
//  lu_a, lu_b and lu_instruction hold their values outside EXEC.
//  Register hazards:
//   - The write completes before returning to IDLE, so the next command reads the updated value.
//   - rd may equal rs1 or rs2: operands are sampled at accept, the write lands at the EXEC edge.
//  Width: no arithmetic in this block; the LU result is taken as-is (N bits).
//  Reset during EXEC or RESP: the command is aborted, rsp_valid drops immediately, and the write is lost.
//  cmd_* inputs are ignored whenever cmd_ready=0.
// TESTING (N=4, M=4)
//  1. Reset, then LOADI r1=0xA and LOADI r2=0xC
//     -> each gives rsp_valid 1 cycle after accept; rsp_data 0xA (rd 1), then 0xC (rd 2).
//  2. op 0 (AND) rd=3, rs1=1, rs2=2
//     -> in EXEC: lu_a=0xA, lu_b=0xC, lu_instruction=0.
//     -> rsp_data=0x8, rsp_rd=3, rsp_valid 2 cycles after accept.
//  3. op 2 (XOR) rd=3 -> 0x6; op 3 (NOR) rd=3 -> 0x1.
//     Then op 6 with rs1=1, rs2=2 -> 0x0; the same op with rs1=2, rs2=1 -> 0x1.
//  4. rd=rs1: op 1 (OR) rd=1, rs1=1, rs2=2 -> 0xE.
//     A following LOADI-free AND with rs1=1, rs2=2 returns 0xC.
//  5. Back-pressure: hold rsp_ready=0 for 5 cycles during RESP
//     -> rsp_valid, rsp_data and rsp_rd stable; cmd_ready=0; a command offered meanwhile is not accepted.
//  6. Assert reset during EXEC -> rsp_valid=0 and lu_*=0 at once.
//     After release, cmd_ready=1 and reading r3 via OR r3,r3 returns 0x0.

Source files
------------

// File: rtl/alu_cmd_sequencer_if.sv
// Command, LU and response signals between the ALU command sequencer and its neighbours.
// The slave modport is the sequencer's view; master is the driver/LU/consumer side.
interface alu_cmd_sequencer_if #(
    parameter int N = 4,
    parameter int M = 4
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [M-1:0] cmd_op;
    logic [1:0]   cmd_rd;
    logic [1:0]   cmd_rs1;
    logic [1:0]   cmd_rs2;
    logic [N-1:0] cmd_imm;
    logic [N-1:0] lu_a;
    logic [N-1:0] lu_b;
    logic [M-2:0] lu_instruction;
    logic [N-1:0] lu_result;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic [1:0]   rsp_rd;

    modport master (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        input  cmd_ready,
        input  lu_a, lu_b, lu_instruction,
        output lu_result,
        input  rsp_valid, rsp_data, rsp_rd,
        output rsp_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm,
        output cmd_ready,
        output lu_a, lu_b, lu_instruction,
        input  lu_result,
        output rsp_valid, rsp_data, rsp_rd,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command-side driver for the combinational logical unit: decodes commands, owns a
// 4-entry register file, drives registered LU operands and returns each write-back.
module alu_cmd_sequencer #(
    parameter int N = 4,
    parameter int M = 4
) (
    input logic                clk,
    input logic                rst,
    alu_cmd_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_rf [4];
    logic [N-1:0] r_lu_a;
    logic [N-1:0] r_lu_b;
    logic [M-2:0] r_lu_instr;
    logic [1:0]   r_rd;
    logic [N-1:0] r_rsp_data;
    logic [1:0]   r_rsp_rd;
    logic         w_cmd_ready;
    logic         w_rsp_valid;
    logic         w_accept;
    logic         w_is_loadi;

    assign w_accept   = bus.cmd_valid & w_cmd_ready;
    assign w_is_loadi = bus.cmd_op[M-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // cmd_ready is gated by rst so nothing can be offered while reset is held
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = ~rst;
                if (w_accept) begin
                    w_next = w_is_loadi ? RESP : EXEC;
                end
            end
            EXEC: begin
                w_next = RESP;
            end
            RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operands are sampled at accept and the write lands at the EXEC edge, so rd may alias rs1/rs2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
            r_lu_a     <= '0;
            r_lu_b     <= '0;
            r_lu_instr <= '0;
            r_rd       <= '0;
            r_rsp_data <= '0;
            r_rsp_rd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_loadi) begin
                            r_rf[bus.cmd_rd] <= bus.cmd_imm;
                            r_rsp_data       <= bus.cmd_imm;
                            r_rsp_rd         <= bus.cmd_rd;
                        end else begin
                            r_lu_a     <= r_rf[bus.cmd_rs1];
                            r_lu_b     <= r_rf[bus.cmd_rs2];
                            r_lu_instr <= bus.cmd_op[M-2:0];
                            r_rd       <= bus.cmd_rd;
                        end
                    end
                end
                EXEC: begin
                    r_rf[r_rd] <= bus.lu_result;
                    r_rsp_data <= bus.lu_result;
                    r_rsp_rd   <= r_rd;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.rsp_valid      = w_rsp_valid;
    assign bus.rsp_data       = r_rsp_data;
    assign bus.rsp_rd         = r_rsp_rd;
    assign bus.lu_a           = r_lu_a;
    assign bus.lu_b           = r_lu_b;
    assign bus.lu_instruction = r_lu_instr;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised and directed bench for alu_cmd_sequencer; a transaction-level model of the
// register file and response timing is compared against the DUT on every falling edge.
module tb_alu_cmd_sequencer;

    localparam int N = 4;
    localparam int M = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic monEn = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.N(N), .M(M)) bus ();

    alu_cmd_sequencer #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference logical unit: AND, OR, XOR, NOR, NAND, XNOR, A>B, A==B
    function automatic logic [N-1:0] luFunc(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [M-2:0] op);
        logic [N-1:0] r;
        case (op)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a ^ b;
            3'd3:    r = ~(a | b);
            3'd4:    r = ~(a & b);
            3'd5:    r = ~(a ^ b);
            3'd6:    r = {{(N-1){1'b0}}, (a > b)};
            default: r = {{(N-1){1'b0}}, (a == b)};
        endcase
        return r;
    endfunction

    always_comb bus.lu_result = luFunc(bus.lu_a, bus.lu_b, bus.lu_instruction);

    logic [N-1:0] mrf [4];
    logic [N-1:0] expLuA;
    logic [N-1:0] expLuB;
    logic [M-2:0] expLuI;
    logic         expReady;
    logic         expValid;
    logic [N-1:0] expData;
    logic [1:0]   expRd;
    logic [N-1:0] rspVal;
    int           passCount = 0;
    int           totalCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (monEn && !rst) begin
            checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(expReady));
            checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(expValid));
            checkOutput("lu_a", 32'(bus.lu_a), 32'(expLuA));
            checkOutput("lu_b", 32'(bus.lu_b), 32'(expLuB));
            checkOutput("lu_instruction", 32'(bus.lu_instruction), 32'(expLuI));
            if (expValid) begin
                checkOutput("rsp_data", 32'(bus.rsp_data), 32'(expData));
                checkOutput("rsp_rd", 32'(bus.rsp_rd), 32'(expRd));
            end
        end
    end

    task automatic randomJunk();
        bus.cmd_op  = M'($urandom_range(0, 2**M - 1));
        bus.cmd_rd  = 2'($urandom_range(0, 3));
        bus.cmd_rs1 = 2'($urandom_range(0, 3));
        bus.cmd_rs2 = 2'($urandom_range(0, 3));
        bus.cmd_imm = N'($urandom_range(0, 2**N - 1));
    endtask

    // Entered just after a rising edge; reset clears the DUT at once
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        checkOutput("reset_lu_a", 32'(bus.lu_a), 32'd0);
        checkOutput("reset_lu_b", 32'(bus.lu_b), 32'd0);
        checkOutput("reset_lu_instruction", 32'(bus.lu_instruction), 32'd0);
        checkOutput("reset_rsp_data", 32'(bus.rsp_data), 32'd0);
        checkOutput("reset_rsp_rd", 32'(bus.rsp_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            mrf[i] = '0;
        end
        expLuA   = '0;
        expLuB   = '0;
        expLuI   = '0;
        expValid = 1'b0;
        expReady = 1'b0;
        expData  = '0;
        expRd    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        expReady = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus.cmd_valid = 1'b0;
            randomJunk();
            @(posedge clk);
            #1;
        end
    endtask

    // Issues one command from idle, models its result and timing, and holds rsp_ready low for 'hold' cycles
    task automatic applyStimulus(input logic [M-1:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [N-1:0] imm, input int hold,
                                 output logic [N-1:0] rspOut);
        logic         isLoad;
        logic [N-1:0] res;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_rd    = rd;
        bus.cmd_rs1   = rs1;
        bus.cmd_rs2   = rs2;
        bus.cmd_imm   = imm;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        isLoad = op[M-1];
        res    = isLoad ? imm : luFunc(mrf[rs1], mrf[rs2], op[M-2:0]);
        #1;
        bus.cmd_valid = 1'b0;
        randomJunk();
        expReady = 1'b0;
        if (!isLoad) begin
            expLuA = mrf[rs1];
            expLuB = mrf[rs2];
            expLuI = op[M-2:0];
            @(posedge clk);
            #1;
        end
        mrf[rd]  = res;
        expValid = 1'b1;
        expData  = res;
        expRd    = rd;
        rspOut   = res;
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            randomJunk();
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        expValid = 1'b0;
        expReady = 1'b1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        randomJunk();
        #1;
        doReset();
        monEn = 1'b1;

        applyStimulus(4'b1000, 2'd1, 2'd0, 2'd0, 4'hA, 0, rspVal);
        checkOutput("t1_loadi_r1", 32'(rspVal), 32'hA);
        applyStimulus(4'b1000, 2'd2, 2'd0, 2'd0, 4'hC, 0, rspVal);
        checkOutput("t1_loadi_r2", 32'(rspVal), 32'hC);
        applyStimulus(4'd0, 2'd3, 2'd1, 2'd2, 4'h0, 0, rspVal);
        checkOutput("t2_and", 32'(rspVal), 32'h8);
        applyStimulus(4'd2, 2'd3, 2'd1, 2'd2, 4'h0, 0, rspVal);
        checkOutput("t3_xor", 32'(rspVal), 32'h6);
        applyStimulus(4'd3, 2'd3, 2'd1, 2'd2, 4'h0, 1, rspVal);
        checkOutput("t3_nor", 32'(rspVal), 32'h1);
        applyStimulus(4'd6, 2'd0, 2'd1, 2'd2, 4'h0, 0, rspVal);
        checkOutput("t3_op6_ab", 32'(rspVal), 32'h0);
        applyStimulus(4'd6, 2'd0, 2'd2, 2'd1, 4'h0, 0, rspVal);
        checkOutput("t3_op6_ba", 32'(rspVal), 32'h1);
        applyStimulus(4'd1, 2'd1, 2'd1, 2'd2, 4'h0, 0, rspVal);
        checkOutput("t4_or_rd_eq_rs1", 32'(rspVal), 32'hE);
        applyStimulus(4'd0, 2'd3, 2'd1, 2'd2, 4'h0, 5, rspVal);
        checkOutput("t4_and_after_write", 32'(rspVal), 32'hC);

        // Abort an LU command while it is in EXEC
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 4'd1;
        bus.cmd_rd    = 2'd3;
        bus.cmd_rs1   = 2'd1;
        bus.cmd_rs2   = 2'd2;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        doReset();
        applyStimulus(4'd1, 2'd3, 2'd3, 2'd3, 4'h0, 0, rspVal);
        checkOutput("t6_r3_after_reset", 32'(rspVal), 32'h0);

        for (int n = 0; n < 60; n++) begin
            logic [M-1:0] rop;
            logic [1:0]   rrd;
            logic [1:0]   rs1;
            logic [1:0]   rs2;
            logic [N-1:0] rimm;
            rop  = M'($urandom_range(0, 2**M - 1));
            rrd  = 2'($urandom_range(0, 3));
            rs1  = 2'($urandom_range(0, 3));
            rs2  = 2'($urandom_range(0, 3));
            rimm = N'($urandom_range(0, 2**N - 1));
            applyStimulus(rop, rrd, rs1, rs2, rimm, $urandom_range(0, 3), rspVal);
            idleCycles($urandom_range(0, 2));
        end

        monEn = 1'b0;
        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
